// File: rtl/gf2m8_arith_unit_if.sv
// ---------------------------------------------------------------------------
// gf2m8_arith_unit_if
// Operand/result bundle for the shared GF(2^8) arithmetic unit.
//   ena    : operation valid, also opens the clock gate of the result regs
//   x, y   : multiplicand / multiplier
//   b      : operand to invert
//   z_c    : combinational product x*y
//   inv_c  : combinational inverse of b
//   z_q    : registered product
//   inv_q  : registered inverse
//   vld    : registered ena, marks z_q/inv_q as freshly loaded
//   gclk   : gated clock, exported for observation
// master drives operands (decoder stage / bench), slave is the arith unit.
// ---------------------------------------------------------------------------
interface gf2m8_arith_unit_if;
  logic       ena;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] b;
  logic [7:0] z_c;
  logic [7:0] inv_c;
  logic [7:0] z_q;
  logic [7:0] inv_q;
  logic       vld;
  logic       gclk;

  modport master (
    output ena, x, y, b,
    input  z_c, inv_c, z_q, inv_q, vld, gclk
  );

  modport slave (
    input  ena, x, y, b,
    output z_c, inv_c, z_q, inv_q, vld, gclk
  );
endinterface

// File: rtl/gf2m8_arith_unit.sv
// ---------------------------------------------------------------------------
// gf2m8_arith_unit
// Shared GF(2^8) datapath (poly 0x11D, alpha = 0x02) for the RS decoder.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : gf2m8_arith_unit_if.slave (operands in, comb/registered results,
//          vld and the gated clock out)
// The result registers run on a latch-based gated clock so they only toggle
// on cycles where ena was high at the rising clk edge.
// ---------------------------------------------------------------------------
module gf2m8_arith_unit #(
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic             clk,
  input  logic             rst,
  gf2m8_arith_unit_if.slave bus
);

  // Carry-less 8x8 product followed by reduction from the top bit down,
  // folding each set bit above bit 7 back with the shifted polynomial.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] m);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) prod = prod ^ ({7'b0, a} << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (prod[i]) prod = prod ^ ({6'b0, POLY} << (i - 8));
    end
    return prod[7:0];
  endfunction

  // b^254 = b^2 * b^4 * ... * b^128. Zero input stays zero naturally,
  // which gives the defined inv(0) = 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_zC;
  logic [7:0] w_invC;
  logic       w_gclk;
  logic       r_enLatch;
  logic [7:0] r_zQ;
  logic [7:0] r_invQ;
  logic       r_vld;

  assign w_zC   = gfMul(bus.x, bus.y);
  assign w_invC = gfInv(bus.b);

  // Enable latch is transparent only while clk is low, so ena changes during
  // the high phase cannot chop or extend a gclk pulse.
  always_latch begin
    if (rst) begin
      r_enLatch <= 1'b0;
    end else if (!clk) begin
      r_enLatch <= bus.ena;
    end
  end

  assign w_gclk = clk & r_enLatch;

  // Result registers only see edges on enabled cycles, so holding is implicit.
  always_ff @(posedge w_gclk or posedge rst) begin
    if (rst) begin
      r_zQ   <= 8'h00;
      r_invQ <= 8'h00;
    end else begin
      r_zQ   <= w_zC;
      r_invQ <= w_invC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else begin
      r_vld <= bus.ena;
    end
  end

  assign bus.z_c   = w_zC;
  assign bus.inv_c = w_invC;
  assign bus.z_q   = r_zQ;
  assign bus.inv_q = r_invQ;
  assign bus.vld   = r_vld;
  assign bus.gclk  = w_gclk;

endmodule

// File: tb/tb_gf2m8_arith_unit.sv
// ---------------------------------------------------------------------------
// tb_gf2m8_arith_unit
// Directed bench for the GF(2^8) arithmetic unit: combinational vectors,
// inverse sweep, clock-gate behaviour, async reset and a random stream
// against an independent shift-and-add field model.
// ---------------------------------------------------------------------------
module tb_gf2m8_arith_unit;

  logic clk;
  logic rst;
  int   numChecks;
  int   numErrors;
  int   gclkPulses;
  logic [7:0] invTab [256];

  gf2m8_arith_unit_if bus ();

  gf2m8_arith_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every gated-clock pulse so idle cycles can be shown pulse-free.
  initial gclkPulses = 0;
  always @(posedge bus.gclk) gclkPulses++;

  // Reference multiply: shift-and-add with xtime by 0x02 mod 0x11D.
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = r ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return r;
  endfunction

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] xv,
                               input logic [7:0] yv, input logic [7:0] bv);
    bus.ena = en;
    bus.x   = xv;
    bus.y   = yv;
    bus.b   = bv;
  endtask

  // Multiplier vectors: x, y, expected product.
  logic [7:0] mulVec [5][3] = '{
    '{8'h02, 8'h80, 8'h1D},
    '{8'hFF, 8'h02, 8'hE3},
    '{8'h03, 8'h03, 8'h05},
    '{8'h00, 8'hA7, 8'h00},
    '{8'h01, 8'h5C, 8'h5C}
  };

  // Inverse vectors: b, expected inverse.
  logic [7:0] invVec [4][2] = '{
    '{8'h01, 8'h01},
    '{8'h02, 8'h8E},
    '{8'h8E, 8'h02},
    '{8'h00, 8'h00}
  };

  initial begin
    logic [7:0] invv;
    logic [7:0] expZ;
    logic [7:0] expInv;
    logic       en;
    logic [7:0] rx, ry, rb;
    int         pulseStart;

    numChecks = 0;
    numErrors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);

    // Brute-force inverse table from the reference multiplier.
    invTab[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      invTab[a] = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (refMul(8'(a), 8'(c)) == 8'h01) invTab[a] = 8'(c);
      end
    end

    #2;
    checkOutput("reset_z_q", bus.z_q, 8'h00);
    checkOutput("reset_inv_q", bus.inv_q, 8'h00);
    checkOutput("reset_vld", {7'b0, bus.vld}, 8'h00);
    checkOutput("reset_gclk", {7'b0, bus.gclk}, 8'h00);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, mulVec[i][0], mulVec[i][1], 8'h00);
      #1;
      checkOutput($sformatf("mul_vec%0d", i), bus.z_c, mulVec[i][2]);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, invVec[i][0]);
      #1;
      checkOutput($sformatf("inv_vec%0d", i), bus.inv_c, invVec[i][1]);
    end

    // Inverse sweep: b*inv(b) = 1, inv(inv(b)) = b, inv matches brute force.
    for (int v = 1; v < 256; v++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 8'(v));
      #1;
      invv = bus.inv_c;
      checkOutput($sformatf("inv_tab_%0d", v), invv, invTab[v]);
      applyStimulus(1'b0, 8'(v), invv, invv);
      #1;
      checkOutput($sformatf("inv_prod_%0d", v), bus.z_c, 8'h01);
      checkOutput($sformatf("inv_inv_%0d", v), bus.inv_c, 8'(v));
    end

    // One enabled cycle, then five idle cycles with changing operands.
    @(negedge clk);
    applyStimulus(1'b1, 8'h02, 8'h80, 8'h02);
    @(posedge clk); #1;
    checkOutput("gate_load_z_q", bus.z_q, 8'h1D);
    checkOutput("gate_load_inv_q", bus.inv_q, 8'h8E);
    checkOutput("gate_load_vld", {7'b0, bus.vld}, 8'h01);
    pulseStart = gclkPulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'(8'h11 * (i + 1)), 8'(8'h23 + i), 8'(8'h40 + i));
      @(posedge clk); #1;
      checkOutput("gate_hold_z_q", bus.z_q, 8'h1D);
      checkOutput("gate_hold_inv_q", bus.inv_q, 8'h8E);
      checkOutput("gate_hold_vld", {7'b0, bus.vld}, 8'h00);
    end
    checkOutput("gate_idle_pulses", 8'(gclkPulses - pulseStart), 8'h00);

    // Glitch: raise ena during the high phase, drop it before the fall.
    bus.ena = 1'b1;
    #1;
    checkOutput("glitch_rise_gclk", {7'b0, bus.gclk}, 8'h00);
    bus.ena = 1'b0;
    pulseStart = gclkPulses;
    @(posedge clk); #1;
    checkOutput("glitch_rise_pulses", 8'(gclkPulses - pulseStart), 8'h00);
    checkOutput("glitch_rise_z_q", bus.z_q, 8'h1D);

    // Latched ena=1; dropping ena while clk is high must not cut the pulse.
    @(negedge clk);
    applyStimulus(1'b1, 8'h03, 8'h03, 8'h03);
    @(posedge clk); #1;
    checkOutput("glitch_fall_gclk_on", {7'b0, bus.gclk}, 8'h01);
    bus.ena = 1'b0;
    #1;
    checkOutput("glitch_fall_gclk_hold", {7'b0, bus.gclk}, 8'h01);
    checkOutput("glitch_fall_z_q", bus.z_q, 8'h05);
    checkOutput("glitch_fall_inv_q", bus.inv_q, invTab[3]);
    pulseStart = gclkPulses;
    @(posedge clk); #1;
    checkOutput("glitch_after_pulses", 8'(gclkPulses - pulseStart), 8'h00);
    checkOutput("glitch_after_vld", {7'b0, bus.vld}, 8'h00);

    // Async reset mid-stream with gclk high.
    @(negedge clk);
    applyStimulus(1'b1, 8'hFF, 8'h02, 8'h02);
    @(posedge clk); #1;
    checkOutput("rst_pre_z_q", bus.z_q, 8'hE3);
    @(negedge clk);
    applyStimulus(1'b1, 8'h03, 8'h03, 8'h01);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_z_q", bus.z_q, 8'h00);
    checkOutput("rst_async_inv_q", bus.inv_q, 8'h00);
    checkOutput("rst_async_vld", {7'b0, bus.vld}, 8'h00);
    checkOutput("rst_async_gclk", {7'b0, bus.gclk}, 8'h00);
    @(posedge clk); #1;
    checkOutput("rst_wins_z_q", bus.z_q, 8'h00);
    checkOutput("rst_wins_vld", {7'b0, bus.vld}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h07, 8'h09, 8'h05);
    @(posedge clk); #1;
    checkOutput("rst_idle_z_q", bus.z_q, 8'h00);
    checkOutput("rst_idle_vld", {7'b0, bus.vld}, 8'h00);
    @(negedge clk);
    applyStimulus(1'b1, 8'h01, 8'h5C, 8'h8E);
    @(posedge clk); #1;
    checkOutput("rst_first_z_q", bus.z_q, 8'h5C);
    checkOutput("rst_first_inv_q", bus.inv_q, 8'h02);
    checkOutput("rst_first_vld", {7'b0, bus.vld}, 8'h01);

    // Random stream against the reference model.
    expZ   = 8'h5C;
    expInv = 8'h02;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(en, rx, ry, rb);
      @(posedge clk); #1;
      if (en) begin
        expZ   = refMul(rx, ry);
        expInv = invTab[rb];
      end
      checkOutput("rand_z_q", bus.z_q, expZ);
      checkOutput("rand_inv_q", bus.inv_q, expInv);
      checkOutput("rand_vld", {7'b0, bus.vld}, {7'b0, en});
    end

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
